// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU sequencer: FSM state codes and ALU opcodes.
package uart_alu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t GET_A  = 3'd0;
  localparam state_t GET_B  = 3'd1;
  localparam state_t GET_OP = 3'd2;
  localparam state_t EXEC   = 3'd3;
  localparam state_t SEND   = 3'd4;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of rx/tx FIFO strobes and ALU operand/result wires around the sequencer.
interface uart_alu_ctrl_if #(
  parameter int DBIT    = 8,
  parameter int OP_BITS = 6
);
  logic               rx_empty;
  logic [DBIT-1:0]    r_data;
  logic               rd_uart;
  logic               tx_full;
  logic               wr_uart;
  logic [DBIT-1:0]    w_data;
  logic [DBIT-1:0]    alu_a;
  logic [DBIT-1:0]    alu_b;
  logic [OP_BITS-1:0] alu_op;
  logic [DBIT-1:0]    alu_result;

  modport master (
    input  rx_empty, r_data, tx_full, alu_result,
    output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op
  );

  modport slave (
    output rx_empty, r_data, tx_full, alu_result,
    input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/uart_alu_timeout.sv
// Idle counter for partial frames: clears on clr, counts on en, ticks at TIMEOUT-1.
module uart_alu_timeout #(
  parameter int TIMEOUT  = 50000000,
  parameter int TMR_BITS = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  logic [TMR_BITS-1:0] cnt;

  assign tick = en && (cnt == TMR_BITS'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || tick) cnt <= '0;
    else if (en)              cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_alu_ctrl.sv
// Pulls A, B, opcode from the rx FIFO, drives the ALU, pushes the result to tx.
// Optional partial-frame timeout: define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int OP_BITS  = 6,
  parameter int TIMEOUT  = 50000000,
  parameter int TMR_BITS = 26
) (
  input  logic            clk,
  input  logic            reset,
  uart_alu_ctrl_if.master bus,
  output logic            busy,
  output logic            frame_err
);

  if ($bits(bus.r_data) != DBIT || (64'(TIMEOUT) >= (64'd1 << TMR_BITS))) begin : g_bad_cfg
    $error("uart_alu_ctrl: bus width or TMR_BITS inconsistent with parameters");
  end

  state_t state, state_nx;
  logic   tmo;
  logic   in_frame;

  assign in_frame = (state == GET_B) || (state == GET_OP);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic tmr_en;
  // Counting only while starved mid-frame; any pop or other state clears it.
  assign tmr_en = in_frame && bus.rx_empty;

  uart_alu_timeout #(.TIMEOUT(TIMEOUT), .TMR_BITS(TMR_BITS)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (!tmr_en),
    .en    (tmr_en),
    .tick  (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= GET_A;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      GET_A:  if (!bus.rx_empty) state_nx = GET_B;
      GET_B:  if (!bus.rx_empty) state_nx = GET_OP;
              else if (tmo)      state_nx = GET_A;
      GET_OP: if (!bus.rx_empty) state_nx = EXEC;
              else if (tmo)      state_nx = GET_A;
      EXEC:                      state_nx = SEND;
      SEND:   if (!bus.tx_full)  state_nx = GET_A;
      default:                   state_nx = GET_A;
    endcase
  end

  always_comb begin
    bus.rd_uart = !reset && (in_frame || state == GET_A) && !bus.rx_empty;
    bus.wr_uart = !reset && (state == SEND) && !bus.tx_full;
    busy        = (state != GET_A);
    frame_err   = !reset && tmo;
  end

  // Operands stay put after SEND so the ALU inputs remain observable.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= '0;
      bus.w_data <= '0;
    end else begin
      case (state)
        GET_A:  if (!bus.rx_empty) bus.alu_a  <= bus.r_data;
        GET_B:  if (!bus.rx_empty) bus.alu_b  <= bus.r_data;
        GET_OP: if (!bus.rx_empty) bus.alu_op <= bus.r_data[OP_BITS-1:0];
        EXEC:                      bus.w_data <= bus.alu_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench: queue-based rx/tx FIFO models and a frame-level ALU reference.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  logic clk, reset;
  logic busy, frame_err;

  uart_alu_ctrl_if #(.DBIT(8), .OP_BITS(6)) u_if ();

  uart_alu_ctrl #(.DBIT(8), .OP_BITS(6), .TIMEOUT(10), .TMR_BITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (u_if),
    .busy      (busy),
    .frame_err (frame_err)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, fe_cnt = 0;
  int last_rd = 0, last_wr = 0, last_fe = 0;
  bit pop_pend = 0;
  logic [7:0] rx_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  logic [5:0] opc_tab [8] = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SRA:     return sa >>> b;
      SRL:     return a >> b;
      NOR:     return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb u_if.alu_result = alu_ref(u_if.alu_a, u_if.alu_b, u_if.alu_op);

  task automatic upd_rx();
    u_if.rx_empty = (rx_q.size() == 0);
    u_if.r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endtask

  task automatic push_rx(input logic [7:0] d);
    rx_q.push_back(d);
    upd_rx();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_out(input int target, input int budget);
    int k;
    k = 0;
    while (out_q.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk("wait_out", 32'(out_q.size() >= target), 32'd1);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Strobes are sampled mid-cycle; the pop they imply lands just after the edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (u_if.rd_uart) begin
        chk("rd_while_empty", 32'(u_if.rx_empty), 32'd0);
        rd_cnt++;
        last_rd = cyc;
        pop_pend = 1;
      end
      if (u_if.wr_uart) begin
        chk("wr_while_full", 32'(u_if.tx_full), 32'd0);
        wr_cnt++;
        last_wr = cyc;
        out_q.push_back(u_if.w_data);
      end
      if (frame_err) begin
        fe_cnt++;
        last_fe = cyc;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      void'(rx_q.pop_front());
      pop_pend = 0;
      upd_rx();
    end
  end

  initial begin
    int rd0, wr0, o0, fe0, k;
    logic [7:0] a, b, op, hold;

    reset = 1;
    u_if.tx_full = 0;
    upd_rx();
    repeat (2) tick();
    reset = 0;
    tick();

    // reset state
    chk("rst_busy",   32'(busy),         32'd0);
    chk("rst_rd",     32'(u_if.rd_uart), 32'd0);
    chk("rst_wr",     32'(u_if.wr_uart), 32'd0);
    chk("rst_alu_a",  32'(u_if.alu_a),   32'd0);
    chk("rst_alu_b",  32'(u_if.alu_b),   32'd0);
    chk("rst_alu_op", 32'(u_if.alu_op),  32'd0);
    chk("rst_w_data", 32'(u_if.w_data),  32'd0);
    chk("rst_ferr",   32'(frame_err),    32'd0);

    // single add frame
    push_rx(8'h05); push_rx(8'h03); push_rx(8'h20);
    wait_out(1, 40);
    tick();
    chk("f1_alu_a",  32'(u_if.alu_a),  32'h05);
    chk("f1_alu_b",  32'(u_if.alu_b),  32'h03);
    chk("f1_alu_op", 32'(u_if.alu_op), 32'h20);
    chk("f1_result", 32'(out_q[0]),    32'h08);
    chk("f1_wr_cnt", 32'(wr_cnt),      32'd1);
    chk("f1_latency", 32'(last_wr - last_rd), 32'd2);
    out_q.delete();

    // three back-to-back frames
    rd0 = rd_cnt; wr0 = wr_cnt;
    foreach (opc_tab[i]) ;
    push_rx(8'h0F); push_rx(8'h01); push_rx(8'h22);
    push_rx(8'hF0); push_rx(8'h0F); push_rx(8'h25);
    push_rx(8'h80); push_rx(8'h01); push_rx(8'h03);
    repeat (15) tick();
    chk("b2b_rd_cnt", 32'(rd_cnt - rd0), 32'd9);
    chk("b2b_wr_cnt", 32'(wr_cnt - wr0), 32'd3);
    wait_out(3, 10);
    chk("b2b_out0", 32'(out_q[0]), 32'h0E);
    chk("b2b_out1", 32'(out_q[1]), 32'hFF);
    chk("b2b_out2", 32'(out_q[2]), 32'hC0);
    out_q.delete();

    // tx stall while in SEND; an extra rx byte must not be consumed
    a = 8'($urandom); b = 8'($urandom); op = {2'b00, opc_tab[$urandom_range(0, 7)]};
    u_if.tx_full = 1;
    push_rx(a); push_rx(b); push_rx(op); push_rx(8'h07);
    repeat (5) tick();
    rd0 = rd_cnt; wr0 = wr_cnt; hold = u_if.w_data;
    repeat (20) tick();
    chk("stall_wr",     32'(wr_cnt - wr0), 32'd0);
    chk("stall_rd",     32'(rd_cnt - rd0), 32'd0);
    chk("stall_busy",   32'(busy),         32'd1);
    chk("stall_w_hold", 32'(u_if.w_data),  32'(hold));
    chk("stall_w_val",  32'(u_if.w_data),  32'(alu_ref(a, b, op[5:0])));
    u_if.tx_full = 0;
    tick();
    chk("stall_rel_wr", 32'(wr_cnt - wr0), 32'd1);
    chk("stall_rel_cyc", 32'(last_wr), 32'(cyc));
    chk("stall_out", 32'(out_q[0]), 32'(alu_ref(a, b, op[5:0])));
    push_rx(8'h03); push_rx(SUB);
    wait_out(2, 40);
    chk("stall_next", 32'(out_q[1]), 32'h04);
    out_q.delete();

    // reset mid-frame discards the partial frame
    push_rx(8'hAA); push_rx(8'h55);
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_alu_a", 32'(u_if.alu_a), 32'd0);
    repeat (5) tick();
    chk("mid_rst_noout", 32'(out_q.size()), 32'd0);
    push_rx(8'h01); push_rx(8'h02); push_rx(8'h20);
    wait_out(1, 40);
    repeat (3) tick();
    chk("mid_rst_out",  32'(out_q[0]),     32'h03);
    chk("mid_rst_size", 32'(out_q.size()), 32'd1);
    out_q.delete();

    // opcode upper bits dropped
    a = 8'($urandom); b = 8'($urandom);
    push_rx(a); push_rx(b); push_rx(8'hE4);
    wait_out(1, 40);
    chk("op_trunc",     32'(u_if.alu_op), 32'h24);
    chk("op_trunc_res", 32'(out_q[0]),    32'(a & b));
    out_q.delete();

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    fe0 = fe_cnt;
    push_rx(8'h11);
    k = 0;
    while (fe_cnt == fe0 && k < 40) begin tick(); k++; end
    tick();
    chk("tmo_pulses", 32'(fe_cnt - fe0),     32'd1);
    chk("tmo_delay",  32'(last_fe - last_rd), 32'd10);
    chk("tmo_busy",   32'(busy),              32'd0);
    push_rx(8'h01); push_rx(8'h02); push_rx(8'h20);
    wait_out(1, 40);
    chk("tmo_next", 32'(out_q[0]), 32'h03);
    out_q.delete();
`endif

    // randomized frames with gaps and tx backpressure
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom % 8);
      op = {2'($urandom), opc_tab[$urandom_range(0, 7)]};
      exp_q.push_back(alu_ref(a, b, op[5:0]));
      push_rx(a);
      repeat ($urandom_range(0, 3)) begin u_if.tx_full = ($urandom_range(0, 3) == 0); tick(); end
      push_rx(b);
      repeat ($urandom_range(0, 3)) begin u_if.tx_full = ($urandom_range(0, 3) == 0); tick(); end
      push_rx(op);
      repeat ($urandom_range(0, 3)) begin u_if.tx_full = ($urandom_range(0, 3) == 0); tick(); end
    end
    u_if.tx_full = 0;
    o0 = exp_q.size();
    wait_out(o0, 400);
    for (int i = 0; i < o0 && i < out_q.size(); i++)
      chk($sformatf("rand_out%0d", i), 32'(out_q[i]), 32'(exp_q[i]));
    tick();
    chk("rand_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
